// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator entropy sampler.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FAIL    = 2'd2
    } trng_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_RCT_LIMIT  = 32;

    // Bits needed to hold a count that runs 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/trng_vn_corrector.sv
// Von Neumann debiaser: pairs raw samples and emits the first bit of unequal pairs.
module trng_vn_corrector (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic sample,
    input  logic flush,
    output logic emit_valid,
    output logic emit_bit
);

    logic pair_flag;
    logic first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_flag <= 1'b0;
            first     <= 1'b0;
        end else if (flush) begin
            pair_flag <= 1'b0;
            first     <= 1'b0;
        end else if (strobe) begin
            if (!pair_flag) begin
                first     <= sample;
                pair_flag <= 1'b1;
            end else begin
                pair_flag <= 1'b0;
            end
        end
    end

    // Emission is combinational so the packer sees the bit on the strobe cycle itself.
    assign emit_valid = strobe && pair_flag && (sample != first) && !flush;
    assign emit_bit   = first;

endmodule

// File: rtl/trng_sampler.sv
// Samples an asynchronous oscillator bit, debiases it, health-tests it and packs it into words.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rnd_in,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             fail_o,
    input  logic             clr_fail_i
);

    localparam int CW    = cnt_width(WIDTH);
    localparam int RCT_W = cnt_width(RCT_LIMIT);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    trng_state_t      state;
    logic             sync_p0;
    logic             s_rnd;
    logic [DIV_W-1:0] div_cnt;
    logic [RCT_W-1:0] rct_cnt;
    logic [RCT_W-1:0] rct_next;
    logic             prev_rnd;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             run;
    logic             strobe;
    logic             trip;
    logic             emit_valid;
    logic             emit_bit;
    logic             accept;
    logic             load;

    // Two-flop synchronizer; only s_rnd is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            s_rnd   <= 1'b0;
        end else begin
            sync_p0 <= rnd_in;
            s_rnd   <= sync_p0;
        end
    end

    // A clear request takes priority over everything else in the collecting path.
    assign run    = (state == ST_COLLECT) && en && !clr_fail_i;
    assign strobe = run && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // A zero count marks the first sample after IDLE.
    assign rct_next = ((rct_cnt == '0) || (s_rnd != prev_rnd)) ? RCT_W'(1) : rct_cnt + RCT_W'(1);
    assign trip     = strobe && (rct_next == RCT_W'(RCT_LIMIT));

    trng_vn_corrector u_vn (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe     (strobe),
        .sample     (s_rnd),
        .flush      (!run || trip),
        .emit_valid (emit_valid),
        .emit_bit   (emit_bit)
    );

    // Bits enter at the MSB and shift down, so the first emitted bit ends up at bit 0.
    assign accept   = emit_valid && (bit_cnt != CW'(WIDTH));
    assign acc_next = accept ? {emit_bit, acc[WIDTH-1:1]} : acc;
    assign cnt_next = accept ? bit_cnt + CW'(1) : bit_cnt;
    assign load     = run && !trip && (cnt_next == CW'(WIDTH)) && (!valid_o || ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            fail_o <= 1'b0;
        end else if (clr_fail_i) begin
            state  <= ST_IDLE;
            fail_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (trip) begin
                        state  <= ST_FAIL;
                        fail_o <= 1'b1;
                    end else if (!en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            rct_cnt  <= '0;
            prev_rnd <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            rct_cnt  <= '0;
        end else begin
            div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            if (strobe) begin
                rct_cnt  <= rct_next;
                prev_rnd <= s_rnd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (!run || trip || load) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else begin
            bit_cnt <= cnt_next;
            acc     <= acc_next;
        end
    end

    // Output register: a new word may load in the same cycle the old one transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_o  <= '0;
            valid_o <= 1'b0;
        end else if (load) begin
            word_o  <= acc_next;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_sampler.sv
// Scoreboard bench for trng_sampler: directed sample streams with hand-computed words.
module tb_trng_sampler;

    localparam int WIDTH      = 8;
    localparam int SAMPLE_DIV = 2;
    localparam int RCT_LIMIT  = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             rnd_in = 1'b0;
    logic             ready_i = 1'b0;
    logic             clr_fail_i = 1'b0;
    logic [WIDTH-1:0] word_o;
    logic             valid_o;
    logic             fail_o;

    int               n_tests = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];

    trng_sampler #(
        .WIDTH      (WIDTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .RCT_LIMIT  (RCT_LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rnd_in     (rnd_in),
        .word_o     (word_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fail_o     (fail_o),
        .clr_fail_i (clr_fail_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted word is compared against the head of the queue.
    always @(negedge clk) begin
        #2;
        if (rst_n && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h, expected none", word_o);
            end else begin
                check("word", 32'(word_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // Each raw value is held for one sample period; sample k is taken from the k-th value.
    task automatic drive(input logic v);
        rnd_in = v;
        repeat (SAMPLE_DIV) @(negedge clk);
    endtask

    // Run a fresh session of n samples (bits[0] first), then disable.
    task automatic session(input logic [63:0] bits, input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) drive(bits[i]);
        drive(1'b0);
        en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pat;

        repeat (3) @(negedge clk);
        #1;
        check("rst_word", 32'(word_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_fail", 32'(fail_o), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Alternating 1,0 / 0,1 pairs -> 0x55
        ready_i = 1'b1;
        exp_q.push_back(8'h55);
        session(64'h9999, 16);
        check("alt_fail", 32'(fail_o), 32'h0);
        check("alt_valid_pulse", 32'(valid_o), 32'h0);

        // 0,1 pairs -> 0x00, then with equal pairs interleaved -> 0x00
        exp_q.push_back(8'h00);
        session(64'hAAAA, 16);
        exp_q.push_back(8'h00);
        session(64'h2E2E_2E2E, 32);

        // Reset with a pending word and 5 bits accumulated
        ready_i = 1'b0;
        en = 1'b1;
        pat = 64'h155_9999;
        for (int i = 0; i < 26; i++) drive(pat[i]);
        drive(1'b0);
        #1;
        check("pre_reset_valid", 32'(valid_o), 32'h1);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("mid_reset_word", 32'(word_o), 32'h0);
        check("mid_reset_valid", 32'(valid_o), 32'h0);
        check("mid_reset_fail", 32'(fail_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hAA);
        session(64'h6666, 16);

        // Backpressure: two 0xFF words while ready is low
        ready_i = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        en = 1'b1;
        for (int i = 0; i < 32; i++) drive((i % 2) == 0);
        drive(1'b0);
        #1;
        check("bp_valid", 32'(valid_o), 32'h1);
        check("bp_word", 32'(word_o), 32'hFF);
        repeat (3) @(negedge clk);
        #1;
        check("bp_hold_valid", 32'(valid_o), 32'h1);
        check("bp_hold_word", 32'(word_o), 32'hFF);
        check("bp_queue", 32'(exp_q.size()), 32'd2);
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        check("bp_second_valid", 32'(valid_o), 32'h1);
        check("bp_second_word", 32'(word_o), 32'hFF);
        check("bp_queue_after", 32'(exp_q.size()), 32'd1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        ready_i = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_drained", 32'(valid_o), 32'h0);

        // Stuck-at-1 source trips the repetition count
        en = 1'b1;
        for (int i = 0; i < RCT_LIMIT; i++) drive(1'b1);
        #1;
        check("rct_before_trip", 32'(fail_o), 32'h0);
        @(negedge clk);
        #1;
        check("rct_trip", 32'(fail_o), 32'h1);
        check("rct_no_word", 32'(valid_o), 32'h0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rct_sticky", 32'(fail_o), 32'h1);
        clr_fail_i = 1'b1;
        @(negedge clk);
        clr_fail_i = 1'b0;
        #1;
        check("rct_cleared", 32'(fail_o), 32'h0);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h55);
        session(64'h9999, 16);
        check("rct_resume_fail", 32'(fail_o), 32'h0);

        // Disable mid-word: partial discarded, pending word kept
        ready_i = 1'b0;
        exp_q.push_back(8'h55);
        session(64'h9999, 16);
        session(64'h15, 6);
        #1;
        check("dis_pending_valid", 32'(valid_o), 32'h1);
        check("dis_pending_word", 32'(word_o), 32'h55);
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hF0);
        session(64'h55AA, 16);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
# trng_sampler

Consumer side of the ring-oscillator entropy source. Samples the free-running asynchronous `rnd` bit into the system clock domain and removes bias with a von Neumann corrector. Runs a repetition-count health test on the raw samples and packs the corrected bits into words. Words are delivered to the design over a valid/ready handshake.

## Interface

Parameters:
- `WIDTH`, 8: output word width in bits (≥2).
- `SAMPLE_DIV`, 4: clocks per raw sample (≥1); decorrelates successive samples.
- `RCT_LIMIT`, 32: consecutive identical raw samples that trip the health test (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  sampling enable.
- `rnd_in`  in  1  raw oscillator bit, asynchronous to `clk`.
- `word_o`  out  WIDTH  random word, valid when `valid_o`=1.
- `valid_o`  out  1  word available.
- `ready_i`  in  1  consumer accepts `word_o` this cycle.
- `fail_o`  out  1  sticky health-test failure.
- `clr_fail_i`  in  1  clears `fail_o` and restarts collection.

## Operation

- Reset values: `word_o`=0, `valid_o`=0, `fail_o`=0. All internal counters, shift register, pair flag and synchronizer flops are 0. State is IDLE.
- Synchronizer: 2-flop chain on `rnd_in`. All logic uses the second flop (`s_rnd`).
- Divider: counts 0..SAMPLE_DIV-1 while in COLLECT. A sample strobe fires when the count equals SAMPLE_DIV-1, then the count wraps to 0. With SAMPLE_DIV=1 the strobe fires every cycle.
- States:
  - IDLE: `en`=0. Divider, pair flag, bit count and RCT counter are held at 0.
  - COLLECT: `en`=1 and no failure.
  - FAIL: `fail_o`=1.
- Transitions:
  - IDLE→COLLECT when `en`=1.
  - COLLECT→IDLE when `en`=0. The partial word and the pair are discarded.
  - COLLECT→FAIL when the RCT trips.
  - FAIL→IDLE on `clr_fail_i`=1. `clr_fail_i` has priority over a simultaneous trip.
- Von Neumann corrector, evaluated on each strobe:
  - Pair flag 0: store the sample as `first` and set the flag.
  - Pair flag 1: clear the flag. If the sample differs from `first`, emit `first` (pair 1,0→1; pair 0,1→0). Equal pairs emit nothing.
- Packing:
  - Emitted bits shift into the accumulator LSB-first; bit k of the word is the k-th emitted bit.
  - Bit count runs 0..WIDTH. When it reaches WIDTH and the output register is empty, or empty-ing in the same cycle, the accumulator moves to `word_o`, `valid_o` is set, and the count returns to 0.
  - If the output register is still full, the accumulator stalls: further emitted bits are dropped, but sampling and the RCT continue.
- Output handshake:
  - `word_o`/`valid_o` are stable while `valid_o`=1 and `ready_i`=0.
  - Transfer occurs on `valid_o`&`ready_i`. `valid_o` then clears unless a new word loads in the same cycle.
  - A pending word survives `en`=0 and FAIL.
- Health test (RCT) on raw samples:
  - The counter resets to 1 whenever the sample differs from the previous one, and increments otherwise.
  - Reaching RCT_LIMIT sets `fail_o` and enters FAIL. FAIL flushes the accumulator and the pair flag; no new words load until cleared.
  - The first sample after IDLE starts the count at 1.

## Timing

- `rnd_in` to `s_rnd`: 2 cycles.
- First strobe: SAMPLE_DIV cycles after entering COLLECT.
- Earliest first word: after 2·WIDTH strobes, with `valid_o` high on the cycle after the last strobe.
- `fail_o` rises the cycle after the RCT_LIMIT-th identical strobe.
- Throughput is limited by the source, never by the handshake, while `ready_i`=1.
- `word_o` is registered; there is no combinational path from `ready_i` to `valid_o`.

## Structure

- Shared package `trng_pkg` holds:
  - the state enum (IDLE, COLLECT, FAIL);
  - default parameter constants;
  - the count-width helper `$clog2(WIDTH+1)`.
- One sub-module is natural: `trng_vn_corrector`, containing the pair flag and `first` register. Inputs are strobe, bit and flush; outputs are emit valid and emit bit.
- The synchronizer stays inline.

## Test plan

Unless noted, all scenarios use WIDTH=8, SAMPLE_DIV=2, RCT_LIMIT=32, and drive `rnd_in` synchronously, one value per strobe.

1. Reset mid-word: with 5 bits accumulated, assert `rst_n`=0 → all outputs 0 immediately. After release, the next word comes from 16 fresh samples.
2. Pairs 1,0 and 0,1 alternating, `ready_i`=1 → `word_o`=0x55, `valid_o` pulses one cycle, `fail_o`=0.
3. Pairs 0,1 repeated → `word_o`=0x00. Interleaving equal pairs 1,1 / 0,0 between them produces no extra bits and still gives 0x00.
4. Backpressure: `ready_i`=0 while two words' worth of pairs 1,0 arrive → `word_o`=0xFF held stable with `valid_o`=1. After `ready_i`=1 for one cycle, the second word 0xFF follows once the accumulator completes.
5. `rnd_in` held at 1 → `fail_o` rises after the 32nd strobe, and no word is produced. `clr_fail_i` pulse → `fail_o`=0, state IDLE; collection resumes with `en`=1.
6. Drop `en` after 3 emitted bits → partial word discarded. Re-enable: the next word uses exactly 8 new bits. A pending `valid_o` word is retained across the disable.
